// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, ALU codes,
// FSM states, instruction classes and writeback/next-PC select values.
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [4:0] ALU_NONE  = 5'd0;
   localparam logic [4:0] ALU_ADD   = 5'd1;
   localparam logic [4:0] ALU_ADDI  = 5'd2;
   localparam logic [4:0] ALU_OR    = 5'd3;
   localparam logic [4:0] ALU_ORI   = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_XORI  = 5'd6;
   localparam logic [4:0] ALU_AND   = 5'd7;
   localparam logic [4:0] ALU_ANDI  = 5'd8;
   localparam logic [4:0] ALU_SUB   = 5'd9;
   localparam logic [4:0] ALU_SLT   = 5'd10;
   localparam logic [4:0] ALU_SLTI  = 5'd11;
   localparam logic [4:0] ALU_SLTU  = 5'd12;
   localparam logic [4:0] ALU_SLTIU = 5'd13;
   localparam logic [4:0] ALU_SLLI  = 5'd14;
   localparam logic [4:0] ALU_SRLI  = 5'd15;
   localparam logic [4:0] ALU_SRAI  = 5'd16;
   localparam logic [4:0] ALU_SLL   = 5'd17;
   localparam logic [4:0] ALU_SRL   = 5'd18;
   localparam logic [4:0] ALU_SRA   = 5'd19;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MDR = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   localparam logic [1:0] PC_PLUS4     = 2'd0;
   localparam logic [1:0] PC_ALU       = 2'd1;
   localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

   typedef enum logic [2:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
   } state_t;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_AUIPC, CL_LUI, CL_ILL
   } iclass_t;

   function automatic iclass_t classify(input logic [6:0] op);
      case (op)
         OP_R:      return CL_R;
         OP_I:      return CL_I;
         OP_LOAD:   return CL_LOAD;
         OP_STORE:  return CL_STORE;
         OP_BRANCH: return CL_BRANCH;
         OP_JAL:    return CL_JAL;
         OP_JALR:   return CL_JALR;
         OP_AUIPC:  return CL_AUIPC;
         OP_LUI:    return CL_LUI;
         default:   return CL_ILL;
      endcase
   endfunction

endpackage

// File: rtl/rv32i_alu_dec.sv
// Combinational ALU decoder: maps opcode/funct3/funct7_b5 to the core's ALU
// code, the ALU B-source select and an instruction legality flag.
module rv32i_alu_dec
   import rv32i_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [4:0] alu_ctrl,
   output logic       bsel,
   output logic       legal
);

   always_comb begin
      alu_ctrl = ALU_NONE;
      bsel     = 1'b0;
      legal    = 1'b1;
      case (classify(opcode))
         CL_R: begin
            // Only SUB and SRA may carry funct7 bit 30.
            legal = !funct7_b5 || (funct3 == 3'b000) || (funct3 == 3'b101);
            case (funct3)
               3'b000:  alu_ctrl = funct7_b5 ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b011:  alu_ctrl = ALU_SLTU;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_AND;
            endcase
         end
         CL_I: begin
            bsel = 1'b1;
            case (funct3)
               3'b000:  alu_ctrl = ALU_ADDI;
               3'b001:  alu_ctrl = ALU_SLLI;
               3'b010:  alu_ctrl = ALU_SLTI;
               3'b011:  alu_ctrl = ALU_SLTIU;
               3'b100:  alu_ctrl = ALU_XORI;
               3'b101:  alu_ctrl = funct7_b5 ? ALU_SRAI : ALU_SRLI;
               3'b110:  alu_ctrl = ALU_ORI;
               default: alu_ctrl = ALU_ANDI;
            endcase
         end
         CL_LUI: alu_ctrl = ALU_NONE;
         CL_ILL: legal = 1'b0;
         default: begin
            // Address/target computations all reuse ADDI with an immediate B.
            alu_ctrl = ALU_ADDI;
            bsel     = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM. Define RV_MC_ILLEGAL_TRAP_EN to halt on
// illegal instructions; otherwise they retire as NOPs.
module rv32i_mc_ctrl
   import rv32i_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int INSTRET_W   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7_b5,
   input  logic                 br_taken,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 addr_sel,
   output logic                 ir_we,
   output logic                 mdr_we,
   output logic [4:0]           alu_ctrl,
   output logic                 asel,
   output logic                 bsel,
   output logic                 rf_we,
   output logic [1:0]           wb_sel,
   output logic                 pc_we,
   output logic [1:0]           pc_sel,
   output logic [INSTRET_W-1:0] instret,
   output logic                 halted,
   output logic                 mem_timeout
);

`ifdef RV_MC_ILLEGAL_TRAP_EN
   localparam bit ILLEGAL_TRAP = 1'b1;
`else
   localparam bit ILLEGAL_TRAP = 1'b0;
`endif

   localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 2);

   state_t               state_reg;
   iclass_t              class_reg;
   logic [4:0]           alu_reg;
   logic                 bsel_reg;
   logic [CNT_W-1:0]     wait_cnt_reg;
   logic [INSTRET_W-1:0] instret_reg;
   logic                 timeout_reg;
   logic [4:0]           dec_alu;
   logic                 dec_bsel;
   logic                 dec_legal;
   logic                 retire;
   logic                 timeout_hit;

   rv32i_alu_dec u_alu_dec (
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .alu_ctrl  (dec_alu),
      .bsel      (dec_bsel),
      .legal     (dec_legal)
   );

   // Trap fires on the wait cycle that would bring the counter to MEM_TIMEOUT-1.
   assign timeout_hit = mem_req && !mem_ready && (wait_cnt_reg == CNT_LAST);
   assign instret     = instret_reg;
   assign halted      = (state_reg == ST_TRAP);
   assign mem_timeout = timeout_reg;

   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      ir_we    = 1'b0;
      mdr_we   = 1'b0;
      alu_ctrl = ALU_NONE;
      asel     = 1'b0;
      bsel     = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = WB_ALU;
      pc_we    = 1'b0;
      pc_sel   = PC_PLUS4;
      retire   = 1'b0;
      // Gating on rst_n lets reset withdraw mem_req without waiting for a clock.
      if (rst_n) begin
         if (state_reg inside {ST_EXEC, ST_MEM, ST_WB}) begin
            alu_ctrl = alu_reg;
            bsel     = bsel_reg;
            asel     = class_reg inside {CL_BRANCH, CL_JAL, CL_AUIPC};
         end
         case (state_reg)
            ST_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
            end
            ST_DECODE: begin
               if (!dec_legal && !ILLEGAL_TRAP) begin
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end
            end
            ST_EXEC: begin
               if (class_reg == CL_BRANCH) begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? PC_ALU : PC_PLUS4;
                  retire = 1'b1;
               end
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (class_reg == CL_STORE);
               if (mem_ready) begin
                  if (class_reg == CL_STORE) begin
                     pc_we  = 1'b1;
                     retire = 1'b1;
                  end else begin
                     mdr_we = 1'b1;
                  end
               end
            end
            ST_WB: begin
               rf_we  = 1'b1;
               pc_we  = 1'b1;
               retire = 1'b1;
               case (class_reg)
                  CL_LOAD: wb_sel = WB_MDR;
                  CL_JAL: begin
                     wb_sel = WB_PC4;
                     pc_sel = PC_ALU;
                  end
                  CL_JALR: begin
                     wb_sel = WB_PC4;
                     pc_sel = PC_ALU_ALIGN;
                  end
                  CL_LUI:  wb_sel = WB_IMM;
                  default: wb_sel = WB_ALU;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_FETCH;
         class_reg    <= CL_R;
         alu_reg      <= ALU_NONE;
         bsel_reg     <= 1'b0;
         wait_cnt_reg <= '0;
         instret_reg  <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         wait_cnt_reg <= (mem_req && !mem_ready) ? wait_cnt_reg + CNT_W'(1) : '0;
         if (retire) begin
            instret_reg <= instret_reg + INSTRET_W'(1);
         end
         case (state_reg)
            ST_FETCH: begin
               if (mem_ready) begin
                  state_reg <= ST_DECODE;
               end else if (timeout_hit) begin
                  state_reg   <= ST_TRAP;
                  timeout_reg <= 1'b1;
               end
            end
            ST_DECODE: begin
               class_reg <= dec_legal ? classify(opcode) : CL_ILL;
               alu_reg   <= dec_alu;
               bsel_reg  <= dec_bsel;
               if (dec_legal) begin
                  state_reg <= ST_EXEC;
               end else begin
                  state_reg <= ILLEGAL_TRAP ? ST_TRAP : ST_FETCH;
               end
            end
            ST_EXEC: begin
               case (class_reg)
                  CL_BRANCH:         state_reg <= ST_FETCH;
                  CL_LOAD, CL_STORE: state_reg <= ST_MEM;
                  default:           state_reg <= ST_WB;
               endcase
            end
            ST_MEM: begin
               if (mem_ready) begin
                  state_reg <= (class_reg == CL_STORE) ? ST_FETCH : ST_WB;
               end else if (timeout_hit) begin
                  state_reg   <= ST_TRAP;
                  timeout_reg <= 1'b1;
               end
            end
            ST_WB:   state_reg <= ST_FETCH;
            ST_TRAP: state_reg <= ST_TRAP;
            default: state_reg <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: walks instruction classes through the FSM
// and checks strobes, selects, retire count and the memory timeout trap.
module tb_rv32i_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst_n2 = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7_b5 = 1'b0;
   logic       br_taken = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_ready2 = 1'b0;

   logic        mem_req, mem_we, addr_sel, ir_we, mdr_we, asel, bsel, rf_we, pc_we, halted, mem_timeout;
   logic [4:0]  alu_ctrl;
   logic [1:0]  wb_sel, pc_sel;
   logic [31:0] instret;

   logic        mem_req_to, mem_we_to, addr_sel_to, ir_we_to, mdr_we_to, asel_to, bsel_to, rf_we_to;
   logic        pc_we_to, halted_to, mem_timeout_to;
   logic [4:0]  alu_ctrl_to;
   logic [1:0]  wb_sel_to, pc_sel_to;
   logic [31:0] instret_to;

   int checks = 0;
   int failures = 0;
   int exp_ret = 0;

   always #5 clk = ~clk;

   rv32i_mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
      .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_we(ir_we), .mdr_we(mdr_we), .alu_ctrl(alu_ctrl), .asel(asel),
      .bsel(bsel), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
      .instret(instret), .halted(halted), .mem_timeout(mem_timeout)
   );

   rv32i_mc_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut_to (
      .clk(clk), .rst_n(rst_n2), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
      .br_taken(br_taken), .mem_ready(mem_ready2), .mem_req(mem_req_to), .mem_we(mem_we_to),
      .addr_sel(addr_sel_to), .ir_we(ir_we_to), .mdr_we(mdr_we_to), .alu_ctrl(alu_ctrl_to),
      .asel(asel_to), .bsel(bsel_to), .rf_we(rf_we_to), .wb_sel(wb_sel_to), .pc_we(pc_we_to),
      .pc_sel(pc_sel_to), .instret(instret_to), .halted(halted_to), .mem_timeout(mem_timeout_to)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs return to idle and outputs settle before checks.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      br_taken  = 1'b0;
      #1;
   endtask

   // Complete a zero-wait fetch of the given instruction; returns in DECODE.
   task automatic fetch(input string name, input logic [6:0] op, input logic [2:0] f3, input logic b5);
      $display("txn %s op=%b f3=%b b5=%b instret=%0d", name, op, f3, b5, instret);
      opcode    = op;
      funct3    = f3;
      funct7_b5 = b5;
      mem_ready = 1'b1;
      #1;
      check({name, "_fetch_req"}, mem_req, 1);
      check({name, "_ir_we"}, ir_we, 1);
      tick();
   endtask

   task automatic run_alu(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic b5, input logic [4:0] exp_alu, input logic exp_bsel);
      fetch(name, op, f3, b5);
      check({name, "_dec_pc_we"}, pc_we, 0);
      tick();
      check({name, "_alu"}, alu_ctrl, exp_alu);
      check({name, "_bsel"}, bsel, exp_bsel);
      check({name, "_asel"}, asel, 0);
      check({name, "_exec_rf_we"}, rf_we, 0);
      tick();
      check({name, "_wb_rf_we"}, rf_we, 1);
      check({name, "_wb_sel"}, wb_sel, 0);
      check({name, "_wb_alu_hold"}, alu_ctrl, exp_alu);
      check({name, "_wb_pc_we"}, pc_we, 1);
      tick();
      exp_ret++;
      check({name, "_instret"}, instret, exp_ret);
      check({name, "_back_fetch"}, mem_req, 1);
   endtask

   task automatic run_ctl(input string name, input logic [6:0] op, input logic [4:0] exp_alu,
                          input logic exp_asel, input logic [1:0] exp_wb, input logic [1:0] exp_pc);
      fetch(name, op, 3'b000, 1'b0);
      tick();
      check({name, "_alu"}, alu_ctrl, exp_alu);
      check({name, "_asel"}, asel, exp_asel);
      tick();
      check({name, "_rf_we"}, rf_we, 1);
      check({name, "_wb_sel"}, wb_sel, exp_wb);
      check({name, "_pc_sel"}, pc_sel, exp_pc);
      tick();
      exp_ret++;
      check({name, "_instret"}, instret, exp_ret);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int mdr_n;
      #12;
      check("rst_mem_req", mem_req, 0);
      check("rst_ir_we", ir_we, 0);
      check("rst_alu", alu_ctrl, 0);
      check("rst_pc_we", pc_we, 0);
      check("rst_wb_sel", wb_sel, 0);
      check("rst_instret", instret, 0);
      check("rst_halted", halted, 0);
      check("rst_timeout", mem_timeout, 0);
      rst_n = 1'b1;
      tick();

      run_alu("add",   7'b0110011, 3'b000, 1'b0, 5'd1,  1'b0);
      run_alu("sub",   7'b0110011, 3'b000, 1'b1, 5'd9,  1'b0);
      run_alu("srai",  7'b0010011, 3'b101, 1'b1, 5'd16, 1'b1);
      run_alu("srli",  7'b0010011, 3'b101, 1'b0, 5'd15, 1'b1);
      run_alu("addi",  7'b0010011, 3'b000, 1'b1, 5'd2,  1'b1);
      run_alu("sltu",  7'b0110011, 3'b011, 1'b0, 5'd12, 1'b0);
      run_alu("xori",  7'b0010011, 3'b100, 1'b0, 5'd6,  1'b1);
      run_alu("sra",   7'b0110011, 3'b101, 1'b1, 5'd19, 1'b0);
      run_alu("slli",  7'b0010011, 3'b001, 1'b0, 5'd14, 1'b1);
      run_alu("and",   7'b0110011, 3'b111, 1'b0, 5'd7,  1'b0);

      fetch("beq", 7'b1100011, 3'b000, 1'b0);
      tick();
      br_taken = 1'b1;
      #1;
      check("beq_pc_we", pc_we, 1);
      check("beq_pc_sel", pc_sel, 1);
      check("beq_asel", asel, 1);
      check("beq_bsel", bsel, 1);
      check("beq_alu", alu_ctrl, 2);
      check("beq_rf_we", rf_we, 0);
      tick();
      exp_ret++;
      check("beq_instret", instret, exp_ret);
      check("beq_back_fetch", mem_req, 1);

      fetch("bne_nt", 7'b1100011, 3'b001, 1'b0);
      tick();
      check("bne_pc_we", pc_we, 1);
      check("bne_pc_sel", pc_sel, 0);
      tick();
      exp_ret++;
      check("bne_instret", instret, exp_ret);

      fetch("lw", 7'b0000011, 3'b010, 1'b0);
      tick();
      check("lw_exec_alu", alu_ctrl, 2);
      check("lw_exec_asel", asel, 0);
      check("lw_exec_bsel", bsel, 1);
      tick();
      n = 0;
      mdr_n = 0;
      for (int i = 0; i < 3; i++) begin
         check("lw_addr_sel", addr_sel, 1);
         if (mem_req) n++;
         if (mdr_we) mdr_n++;
         tick();
      end
      mem_ready = 1'b1;
      #1;
      if (mem_req) n++;
      if (mdr_we) mdr_n++;
      check("lw_mem_we", mem_we, 0);
      check("lw_mem_pc_we", pc_we, 0);
      tick();
      if (mdr_we) mdr_n++;
      check("lw_req_cycles", n, 4);
      check("lw_mdr_pulses", mdr_n, 1);
      check("lw_wb_sel", wb_sel, 1);
      check("lw_wb_rf_we", rf_we, 1);
      check("lw_wb_alu_hold", alu_ctrl, 2);
      tick();
      exp_ret++;
      check("lw_instret", instret, exp_ret);

      fetch("sw", 7'b0100011, 3'b010, 1'b0);
      tick();
      tick();
      mem_ready = 1'b1;
      #1;
      check("sw_mem_we", mem_we, 1);
      check("sw_addr_sel", addr_sel, 1);
      check("sw_pc_we", pc_we, 1);
      check("sw_mdr_we", mdr_we, 0);
      check("sw_rf_we", rf_we, 0);
      tick();
      exp_ret++;
      check("sw_instret", instret, exp_ret);
      check("sw_back_fetch", mem_req, 1);

      run_ctl("jal",   7'b1101111, 5'd2, 1'b1, 2'd2, 2'd1);
      run_ctl("jalr",  7'b1100111, 5'd2, 1'b0, 2'd2, 2'd2);
      run_ctl("lui",   7'b0110111, 5'd0, 1'b0, 2'd3, 2'd0);
      run_ctl("auipc", 7'b0010111, 5'd2, 1'b1, 2'd0, 2'd0);

      fetch("sw_rst", 7'b0100011, 3'b010, 1'b0);
      tick();
      tick();
      check("rstmem_req_before", mem_req, 1);
      rst_n = 1'b0;
      #1;
      check("rstmem_req_dropped", mem_req, 0);
      check("rstmem_instret", instret, 0);
      exp_ret = 0;
      rst_n = 1'b1;
      tick();

      fetch("illegal", 7'b0000000, 3'b000, 1'b0);
`ifdef RV_MC_ILLEGAL_TRAP_EN
      check("ill_pc_we", pc_we, 0);
      tick();
      check("ill_halted", halted, 1);
      check("ill_instret", instret, exp_ret);
      check("ill_trap_req", mem_req, 0);
`else
      check("ill_pc_we", pc_we, 1);
      check("ill_pc_sel", pc_sel, 0);
      check("ill_rf_we", rf_we, 0);
      tick();
      exp_ret++;
      check("ill_instret", instret, exp_ret);
      check("ill_halted", halted, 0);
      check("ill_back_fetch", mem_req, 1);
      fetch("sll_b5", 7'b0110011, 3'b001, 1'b1);
      check("sllb5_pc_we", pc_we, 1);
      tick();
      exp_ret++;
      check("sllb5_instret", instret, exp_ret);
`endif

      check("to_rst_halted", halted_to, 0);
      check("to_rst_req", mem_req_to, 0);
      rst_n2 = 1'b1;
      #1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (halted_to) break;
         if (mem_req_to) n++;
         tick();
      end
      check("to_wait_cycles", n, 3);
      check("to_halted", halted_to, 1);
      check("to_mem_timeout", mem_timeout_to, 1);
      check("to_trap_req", mem_req_to, 0);
      check("to_trap_ir_we", ir_we_to, 0);
      check("to_instret", instret_to, 0);
      rst_n2 = 1'b0;
      #1;
      check("to_clr_halted", halted_to, 0);
      check("to_clr_timeout", mem_timeout_to, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and single memory port. It drives the 5-bit ALU operation code directly, using the core's existing encoding, along with all datapath mux selects and write enables. It also counts retired instructions and traps on memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before trapping; must be >= 2.
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instruction register bits [6:0]
funct3  in  3  instruction register bits [14:12]
funct7_b5  in  1  instruction register bit 30
br_taken  in  1  branch comparator result for current funct3, valid in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request strobe
mem_we  out  1  1 = store
addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result
ir_we  out  1  load instruction register
mdr_we  out  1  load memory data register
alu_ctrl  out  5  ALU operation code
asel  out  1  ALU A source: 0 = rs1, 1 = PC
bsel  out  1  ALU B source: 0 = rs2, 1 = immediate
rf_we  out  1  register file write enable
wb_sel  out  2  writeback source: 0 = ALU, 1 = MDR, 2 = PC+4, 3 = immediate
pc_we  out  1  PC write enable
pc_sel  out  2  next PC: 0 = PC+4, 1 = ALU, 2 = ALU with bit0 cleared
instret  out  INSTRET_W  retired-instruction count
halted  out  1  FSM is in TRAP
mem_timeout  out  1  sticky; set on memory timeout

Behaviour:
- Reset (async, rst_n=0): state = FETCH, wait counter = 0, instret = 0, mem_timeout = 0. All strobes/enables = 0; alu_ctrl = 0, selects = 0.
- Strobes (mem_req, ir_we, mdr_we, rf_we, pc_we) are combinational from state plus inputs, and are 0 in any state not listed.
- ALU codes: ADD=1, ADDI=2, OR=3, ORI=4, XOR=5, XORI=6, AND=7, ANDI=8, SUB=9, SLT=10, SLTI=11, SLTU=12, SLTIU=13, SLLI=14, SRLI=15, SRAI=16, SLL=17, SRL=18, SRA=19; 0 = none.
- R-type (0110011): decode from funct3/funct7_b5, bsel = 0. funct7_b5 = 1 only valid for SUB/SRA.
- I-ALU (0010011): bsel = 1. funct7_b5 is used only for f3 = 101 (SRLI/SRAI); ADDI ignores it.
- FETCH: mem_req = 1, addr_sel = 0. On mem_ready: ir_we = 1, go to DECODE.
- DECODE: 1 cycle; classify opcode. Unknown opcode, or invalid funct7_b5 combination, is illegal.
- EXEC: alu_ctrl/asel/bsel driven per class:
  - R/I: go to WB.
  - LOAD/STORE: ADDI, asel = 0, bsel = 1; go to MEM.
  - BRANCH: ADDI, asel = 1, bsel = 1; pc_we = 1, pc_sel = br_taken ? 1 : 0; instret++; go to FETCH.
  - JAL / AUIPC: ADDI, asel = 1; go to WB.
  - JALR: ADDI, asel = 0; go to WB.
  - LUI: go to WB.
- MEM: mem_req = 1, addr_sel = 1, mem_we = store; ALU controls held from EXEC. On mem_ready:
  - store: pc_we = 1, pc_sel = 0, instret++, go to FETCH.
  - load: mdr_we = 1, go to WB.
- WB: rf_we = 1, pc_we = 1, instret++, go to FETCH.
  - wb_sel: ALU for R/I/AUIPC; MDR for load; PC+4 for JAL/JALR; IMM for LUI.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - ALU controls held from EXEC.
- Wait counter:
  - Cleared on entry to FETCH/MEM and when mem_ready.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - Reaching MEM_TIMEOUT-1 with mem_ready = 0: set mem_timeout, go to TRAP, no ir_we/mdr_we.
  - mem_ready in that same cycle wins.
- TRAP: halted = 1, all enables 0; exit only via reset.
- instret wraps modulo 2^INSTRET_W.
- Reset mid-MEM drops mem_req asynchronously; the memory must abandon the request.

Optional Feature:
RV_MC_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to TRAP (halted = 1, instret unchanged).
- Undefined: an illegal instruction is a NOP; DECODE asserts pc_we = 1, pc_sel = 0, instret++, goes to FETCH.

Decomposition:
- Package rv32i_pkg: opcode constants, ALU code constants (1..19), FSM state encoding, wb_sel/pc_sel encodings.
- One sub-module: rv32i_alu_dec, combinational (opcode, funct3, funct7_b5 -> alu_ctrl, bsel, legal). The FSM instantiates it.

Test Plan:
- ADD x3,x1,x2 with 0-wait memory → FETCH, DECODE, EXEC, WB: 4 cycles; alu_ctrl = 1, bsel = 0, rf_we = 1, wb_sel = 0; instret 0→1.
- SRAI (f3 = 101, funct7_b5 = 1) → alu_ctrl = 16, bsel = 1; SUB (R, f3 = 000, b5 = 1) → 9.
- BEQ with br_taken = 1 → in EXEC pc_we = 1, pc_sel = 1, asel = 1, no rf_we; 3 cycles total.
- LW with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles, addr_sel = 1; mdr_we pulses once; WB wb_sel = 1.
- MEM_TIMEOUT = 4, mem_ready never asserted in FETCH → TRAP after 3 waiting cycles; halted = 1, mem_timeout = 1; rst_n low clears both.
- Opcode 0000000 → with the macro: halted = 1; without it: pc_we in DECODE, instret++, back to FETCH.
